ssd_scan_ctrl: RTL

Time-multiplexed scan controller for the board's four-digit seven-segment display. It shares the single segment bus (`pattern`) among four digit slots by rotating the active-low digit enable (`position`) at a fixed refresh rate. It also latches new display contents atomically at frame boundaries through a req/ack handshake. It sits between the counter/datapath logic that produces the 4-bit digit values and the board SSD pins, replacing a fixed single-digit enable.

---
 rtl/ssd_pkg.sv | 43 ++++
 rtl/ssd_refresh_div.sv | 19 +
 rtl/ssd_scan_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: segment constants, digit-enable constants and hex decoder for the SSD scan controller
// Segment bytes are {a,b,c,d,e,f,g,dp}, active-low; the dp bit is 1 (off) in every hex constant.
package ssd_pkg;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0 = 8'b0000_0011;
    localparam logic [7:0] SEG_1 = 8'b1001_1111;
    localparam logic [7:0] SEG_2 = 8'b0010_0101;
    localparam logic [7:0] SEG_3 = 8'b0000_1101;
    localparam logic [7:0] SEG_4 = 8'b1001_1001;
    localparam logic [7:0] SEG_5 = 8'b0100_1001;
    localparam logic [7:0] SEG_6 = 8'b0100_0001;
    localparam logic [7:0] SEG_7 = 8'b0001_1111;
    localparam logic [7:0] SEG_8 = 8'b0000_0001;
    localparam logic [7:0] SEG_9 = 8'b0000_1001;
    localparam logic [7:0] SEG_A = 8'b0001_0001;
    localparam logic [7:0] SEG_B = 8'b1100_0001;
    localparam logic [7:0] SEG_C = 8'b0110_0011;
    localparam logic [7:0] SEG_D = 8'b1000_0101;
    localparam logic [7:0] SEG_E = 8'b0110_0001;
    localparam logic [7:0] SEG_F = 8'b0111_0001;
    localparam logic [3:0] POS_OFF = 4'b1111;
    typedef enum logic {UPD_IDLE, UPD_ACK} upd_state_t;
    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction
endpackage

// File: rtl/ssd_refresh_div.sv
// ssd_refresh_div: digit-slot prescaler, pulses tick once every REFRESH_DIV enabled cycles
// Ports: clk, rst_n (async active-low), en (count enable, holds count when low), tick (slot end).
module ssd_refresh_div #(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    logic [DIV_W-1:0] div_cnt;
    assign tick = en && div_cnt == DIV_W'(REFRESH_DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else if (en) div_cnt <= div_cnt + DIV_W'(1);
    end
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: four-digit seven-segment scan controller with frame-atomic display updates
// Ports: clk, rst_n (async active-low); en (scan enable, dark and frozen when low);
//   digits[15:0] (digit k in [4k+3:4k]); dp_in[3:0] (1 = lit); blank_lz (leading-zero blanking);
//   upd_req/upd_ack (level request, one-cycle ack once the shadow is loaded);
//   position[3:0] (active-low digit enable); pattern[7:0] ({a..g,dp}, active-low).
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic [3:0]  position,
    output logic [7:0]  pattern
);
    logic tick, fb, load, blank;
    logic [1:0] idx;
    logic [15:0] sh_dig;
    logic [3:0] sh_dp, nib, position_d;
    logic [7:0] seg, pattern_d;
    upd_state_t state, state_nxt;

    ssd_refresh_div #(.REFRESH_DIV(REFRESH_DIV), .DIV_W(DIV_W)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (tick)
    );

    assign fb = tick && idx == 2'd3;
    assign upd_ack = state == UPD_ACK;

    // Shadow only changes at a frame boundary (or while dark), so a frame never mixes old and new data.
    always_comb begin
        load = upd_req && (fb || !en);
        state_nxt = load ? UPD_ACK : UPD_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= UPD_IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd0;
            sh_dig <= '0;
            sh_dp <= '0;
        end else begin
            if (tick) idx <= idx + 2'd1;
            if (load) begin
                sh_dig <= digits;
                sh_dp <= dp_in;
            end
        end
    end

    // Digit idx is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        nib = sh_dig[{idx, 2'b00} +: 4];
        blank = blank_lz && idx != 2'd0 && (sh_dig >> {idx, 2'b00}) == 16'd0;
        seg = blank ? SEG_BLANK : hex2seg(nib);
        pattern_d = en ? {seg[7:1], ~sh_dp[idx]} : SEG_BLANK;
        position_d = en ? ~(4'b0001 << idx) : POS_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position <= POS_OFF;
            pattern <= SEG_BLANK;
        end else begin
            position <= position_d;
            pattern <= pattern_d;
        end
    end
endmodule
